// File: rtl/dm_bytelane.sv
// dm_bytelane: single-port synchronous data RAM for the MIPS datapath.
// Byte/halfword/word stores with byte-lane writes, sign/zero-extended loads,
// registered one-cycle read, ready/valid handshake and a post-reset zero-fill sweep.
//
// Ports:
//   clk_i     clock, all state updates on the rising edge
//   rst_ni    asynchronous active-low reset
//   req_i     access request, accepted when req_i && ready_o
//   we_i      1 = store, 0 = load
//   size_i    00 byte, 01 halfword, 10 word, 11 treated as word
//   sext_i    loads: 1 = sign-extend, 0 = zero-extend
//   addr_i    byte address
//   din_i     store data, right-justified
//   ready_o   block can accept a request this cycle
//   rvalid_o  one-cycle pulse, dout_o holds the load result
//   dout_o    extended load data, held between loads
//   err_o     one-cycle misaligned-access pulse
//
// Optional feature: define DM_ALIGN_CHECK_EN to flag misaligned half/word
// accesses (no write, zero load data, err_o pulse). Without it, low address
// bits are forced aligned and err_o is tied low.

module dm_bytelane #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  sext_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           din_i,
    output logic                  ready_o,
    output logic                  rvalid_o,
    output logic [31:0]           dout_o,
    output logic                  err_o
);

    localparam int unsigned IdxW  = ADDR_WIDTH - 2;
    localparam int unsigned Depth = 2 ** IdxW;

    typedef enum logic {StInit, StIdle} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   cnt_q, cnt_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       dout_q, dout_d;

    logic [31:0]       mem_q [Depth];

    logic              accept;
    logic              misal;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [1:0]        off;
    logic [31:0]       rword;
    logic [31:0]       shifted;
    logic [31:0]       ext;
    logic [3:0]        mem_we;
    logic [IdxW-1:0]   mem_idx;
    logic [31:0]       mem_wdata;

    // Lane decode, alignment and load extraction.
    always_comb begin
        be    = 4'b1111;
        wdata = din_i;
        off   = 2'b00;
        case (size_i)
            2'b00: begin
                be    = 4'b0001 << addr_i[1:0];
                wdata = {4{din_i[7:0]}};
                off   = addr_i[1:0];
            end
            2'b01: begin
                be    = 4'b0011 << {addr_i[1], 1'b0};
                wdata = {2{din_i[15:0]}};
                off   = {addr_i[1], 1'b0};
            end
            default: ;
        endcase

`ifdef DM_ALIGN_CHECK_EN
        misal = ((size_i == 2'b01) && addr_i[0]) || (size_i[1] && (addr_i[1:0] != 2'b00));
`else
        misal = 1'b0;
`endif

        // Combinational read returns contents before any write at this edge.
        rword   = mem_q[addr_i[ADDR_WIDTH-1:2]];
        shifted = rword >> {off, 3'b000};
        case (size_i)
            2'b00:   ext = {{24{sext_i & shifted[7]}}, shifted[7:0]};
            2'b01:   ext = {{16{sext_i & shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    // Control, sweep counter and registered outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = req_i && (state_q == StIdle);
        mem_we    = 4'b0000;
        mem_idx   = addr_i[ADDR_WIDTH-1:2];
        mem_wdata = wdata;
        rvalid_d  = accept && !we_i;
        dout_d    = dout_q;

        if (state_q == StInit) begin
            mem_we    = 4'b1111;
            mem_idx   = cnt_q;
            mem_wdata = 32'h0;
            cnt_d     = cnt_q + IdxW'(1);
            if (&cnt_q) begin
                state_d = StIdle;
            end
        end else if (accept && we_i && !misal) begin
            mem_we = be;
        end

        if (rvalid_d) begin
            dout_d = misal ? 32'h0 : ext;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StInit;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            dout_q   <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            dout_q   <= dout_d;
        end
    end

    // Storage has no reset; the sweep clears it.
    always_ff @(posedge clk_i) begin
        for (int l = 0; l < 4; l++) begin
            if (mem_we[l]) begin
                mem_q[mem_idx][8*l +: 8] <= mem_wdata[8*l +: 8];
            end
        end
    end

`ifdef DM_ALIGN_CHECK_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && misal;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign ready_o  = (state_q == StIdle);
    assign rvalid_o = rvalid_q;
    assign dout_o   = dout_q;

endmodule

// File: tb/tb_dm_bytelane.sv
// Directed testbench for dm_bytelane (ADDR_WIDTH = 12, 1024-word sweep).
module tb_dm_bytelane;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [11:0] addr;
    logic [31:0] din;
    logic        ready;
    logic        rvalid;
    logic [31:0] dout;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    dm_bytelane #(.ADDR_WIDTH(12)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (req),
        .we_i     (we),
        .size_i   (size),
        .sext_i   (sext),
        .addr_i   (addr),
        .din_i    (din),
        .ready_o  (ready),
        .rvalid_o (rvalid),
        .dout_o   (dout),
        .err_o    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [1:0] sz, input logic [11:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; size = sz; sext = 1'b0; addr = a; din = d;
        tick();
        req = 1'b0; we = 1'b0;
    endtask

    task automatic load(input logic [1:0] sz, input logic sx, input logic [11:0] a,
                        output logic [31:0] d, output logic rv, output logic er);
        req = 1'b1; we = 1'b0; size = sz; sext = sx; addr = a; din = 32'h0;
        tick();
        req = 1'b0;
        d  = dout;
        rv = rvalid;
        er = err;
    endtask

    // Counts edges until ready rises; bounded, also notes any rvalid pulse seen.
    task automatic wait_init(output int n, output logic saw_rv);
        n = 0;
        saw_rv = 1'b0;
        while (!ready && n < 2000) begin
            tick();
            n++;
            saw_rv |= rvalid;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        rv;
        logic        er;
        logic        saw;
        int          n;

        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
        addr = '0; din = '0;
        repeat (3) tick();
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_dout", dout, 32'h0);
        check("rst_err", {31'b0, err}, 32'd0);

        rst_n = 1'b1;
        wait_init(n, saw);
        check("init_cycles", n, 32'd1024);

        load(2'b10, 1'b0, 12'h3FC, d, rv, er);
        check("lw_3fc_rvalid", {31'b0, rv}, 32'd1);
        check("lw_3fc_data", d, 32'h0);
        tick();
        check("rvalid_pulse", {31'b0, rvalid}, 32'd0);

        store(2'b10, 12'h010, 32'h12345678);
        check("sw_no_rvalid", {31'b0, rvalid}, 32'd0);
        store(2'b00, 12'h011, 32'h000000AB);
        load(2'b10, 1'b0, 12'h010, d, rv, er);
        check("sb_merge_rvalid", {31'b0, rv}, 32'd1);
        check("sb_merge", d, 32'h1234AB78);

        store(2'b10, 12'h020, 32'h80F07F01);
        load(2'b00, 1'b1, 12'h020, d, rv, er);
        check("lb_020", d, 32'h00000001);
        load(2'b00, 1'b1, 12'h023, d, rv, er);
        check("lb_023", d, 32'hFFFFFF80);
        load(2'b00, 1'b0, 12'h023, d, rv, er);
        check("lbu_023", d, 32'h00000080);
        load(2'b01, 1'b1, 12'h022, d, rv, er);
        check("lh_022", d, 32'hFFFF80F0);
        load(2'b01, 1'b0, 12'h020, d, rv, er);
        check("lhu_020", d, 32'h00007F01);
        load(2'b10, 1'b1, 12'h020, d, rv, er);
        check("lw_sext_ignored", d, 32'h80F07F01);

        // dout holds after the pulse
        tick();
        check("dout_hold_rvalid", {31'b0, rvalid}, 32'd0);
        check("dout_hold", dout, 32'h80F07F01);

        store(2'b10, 12'h040, 32'hDEADBEEF);
        check("b2b_ready", {31'b0, ready}, 32'd1);
        load(2'b10, 1'b0, 12'h040, d, rv, er);
        check("b2b_rvalid", {31'b0, rv}, 32'd1);
        check("b2b_data", d, 32'hDEADBEEF);

`ifdef DM_ALIGN_CHECK_EN
        store(2'b01, 12'h041, 32'h0000FFFF);
        check("mis_sh_err", {31'b0, err}, 32'd1);
        tick();
        check("mis_err_pulse", {31'b0, err}, 32'd0);
        load(2'b10, 1'b0, 12'h040, d, rv, er);
        check("mis_sh_nowrite", d, 32'hDEADBEEF);
        check("aligned_no_err", {31'b0, er}, 32'd0);
        load(2'b10, 1'b0, 12'h042, d, rv, er);
        check("mis_lw_rvalid", {31'b0, rv}, 32'd1);
        check("mis_lw_data", d, 32'h0);
        check("mis_lw_err", {31'b0, er}, 32'd1);
`else
        store(2'b01, 12'h041, 32'h0000FFFF);
        check("noalign_sh_err", {31'b0, err}, 32'd0);
        load(2'b10, 1'b0, 12'h040, d, rv, er);
        check("noalign_sh_forced", d, 32'hDEADFFFF);
        load(2'b10, 1'b0, 12'h042, d, rv, er);
        check("noalign_lw_forced", d, 32'hDEADFFFF);
        check("noalign_lw_err", {31'b0, er}, 32'd0);
`endif
        load(2'b11, 1'b1, 12'h020, d, rv, er);
        check("size11_as_word", d, 32'h80F07F01);

        // Reset while a load request is pending.
        tick();
        req = 1'b1; we = 1'b0; size = 2'b10; sext = 1'b0; addr = 12'h040;
        #3 rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'b0, ready}, 32'd0);
        check("midrst_rvalid", {31'b0, rvalid}, 32'd0);
        check("midrst_dout", dout, 32'h0);
        tick();
        req = 1'b0;
        check("midrst_rvalid_edge", {31'b0, rvalid}, 32'd0);
        #2 rst_n = 1'b1;
        wait_init(n, saw);
        check("midrst_no_rvalid", {31'b0, saw}, 32'd0);
        check("midrst_init_cycles", n, 32'd1024);
        load(2'b10, 1'b0, 12'h040, d, rv, er);
        check("midrst_swept", d, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
